// File: rtl/pkt_key_parser.sv
// pkt_key_parser
//   Passive tap on a 64-bit ingress AXI-Stream. It walks the first five beats of
//   every frame, checks for plain IPv4 (IHL=5) carrying UDP, and emits one 96-bit
//   lookup key {src_ip, dst_ip, udp_dport, 16'h0} with an op flag and a 1-cycle
//   strobe per qualifying frame. Frames that are not IPv4/UDP, carry IP options or
//   end before the fifth beat produce no key.
//
//   Optional build macro: PARSER_STATS_EN
//     defined   : stat_frames / stat_keys / stat_drops count frame ends, emitted
//                 keys and rejected frames (wrapping modulo 2^CNT_WIDTH).
//     undefined : stat_* outputs are tied to zero and no counter logic exists.
//
//   Handshake: a beat is transferred only when s_axis_tvalid and s_axis_tready are
//   both high on a rising clk edge. This block never drives tready; it only
//   observes transfers, so it cannot back-pressure the stream. out_valid is a
//   single-cycle strobe with no ready; out_key/out_flag hold between strobes.
//
//   Frame byte map (byte n of a beat is tdata[8n+7:8n], fields big-endian):
//     beat 1 : ethertype bytes 12-13 == 16'h0800, byte 14 == 8'h45
//     beat 2 : byte 23 (IP protocol) == 8'd17
//     beat 3 : src_ip bytes 26-29, dst_ip[31:16] bytes 30-31
//     beat 4 : dst_ip[15:0] bytes 32-33, sport 34-35, dport 36-37; tkeep[5:0] full
module pkt_key_parser #(
  parameter int          KEY_SIZE   = 96,
  parameter int          DATA_WIDTH = 64,
  parameter logic [15:0] WATCH_PORT = 16'd53,
  parameter int          CNT_WIDTH  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                    s_axis_tvalid,
  input  logic                    s_axis_tready,
  input  logic                    s_axis_tlast,
  output logic [KEY_SIZE-1:0]     out_key,
  output logic [3:0]              out_flag,
  output logic                    out_valid,
  output logic [CNT_WIDTH-1:0]    stat_frames,
  output logic [CNT_WIDTH-1:0]    stat_keys,
  output logic [CNT_WIDTH-1:0]    stat_drops,
  output logic [2:0]              dbg_state
);

  localparam logic [3:0] FLAG_LOOKUP = 4'd1;
  localparam logic [3:0] FLAG_INSERT = 4'd2;

  // One state per header beat, then SKIP for the payload until tlast.
  typedef enum logic [2:0] {
    ST_B0   = 3'd0,
    ST_B1   = 3'd1,
    ST_B2   = 3'd2,
    ST_B3   = 3'd3,
    ST_B4   = 3'd4,
    ST_SKIP = 3'd5
  } state_e;

  state_e state_q, state_d;

  // Header fields captured on beat 3, consumed when beat 4 arrives.
  logic [31:0] src_ip_q, src_ip_d;
  logic [15:0] dst_hi_q, dst_hi_d;

  // Sticky per-frame reject mark; cleared at the frame's tlast beat.
  logic drop_q, drop_d;

  logic [KEY_SIZE-1:0] out_key_q, out_key_d;
  logic [3:0]          out_flag_q, out_flag_d;
  logic                out_valid_q, out_valid_d;

  logic        beat;
  logic [7:0]  lane [8];
  logic        b1_ok;
  logic        b2_ok;
  logic        keep_ok;
  logic [15:0] dst_lo;
  logic [15:0] sport;
  logic [15:0] dport;
  logic        fail_now;
  logic        emit;

  // Only tkeep[5:0] of beat 4 matters (the bytes holding dst_ip low, sport, dport).
  logic unused_keep;
  assign unused_keep = ^s_axis_tkeep[DATA_WIDTH/8-1:6];

  assign beat = s_axis_tvalid & s_axis_tready;

  // Split the beat into byte lanes so the checks read like the byte map above.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      lane[i] = s_axis_tdata[8*i +: 8];
    end
  end

  // Per-beat header checks and field extraction; only meaningful in the matching state.
  always_comb begin
    b1_ok   = ({lane[4], lane[5]} == 16'h0800) && (lane[6] == 8'h45);
    b2_ok   = (lane[7] == 8'd17);
    keep_ok = (s_axis_tkeep[5:0] == 6'h3F);
    dst_lo  = {lane[0], lane[1]};
    sport   = {lane[2], lane[3]};
    dport   = {lane[4], lane[5]};
  end

  // FSM next state, field capture, reject tracking and key emission.
  always_comb begin
    state_d     = state_q;
    src_ip_d    = src_ip_q;
    dst_hi_d    = dst_hi_q;
    drop_d      = drop_q;
    out_key_d   = out_key_q;
    out_flag_d  = out_flag_q;
    out_valid_d = 1'b0;
    fail_now    = 1'b0;
    emit        = 1'b0;

    if (beat) begin
      unique case (state_q)
        ST_B0: begin
          state_d = ST_B1;
        end
        ST_B1: begin
          if (b1_ok) begin
            state_d = ST_B2;
          end else begin
            fail_now = 1'b1;
            state_d  = ST_SKIP;
          end
        end
        ST_B2: begin
          if (b2_ok) begin
            state_d = ST_B3;
          end else begin
            fail_now = 1'b1;
            state_d  = ST_SKIP;
          end
        end
        ST_B3: begin
          src_ip_d = {lane[2], lane[3], lane[4], lane[5]};
          dst_hi_d = {lane[6], lane[7]};
          state_d  = ST_B4;
        end
        ST_B4: begin
          // drop_q cannot be set here since B1/B2 failures leave via SKIP,
          // but it is kept in the term so a reject is never overridden.
          if (keep_ok && !drop_q) begin
            emit = 1'b1;
          end else begin
            fail_now = 1'b1;
          end
          state_d = ST_SKIP;
        end
        ST_SKIP: begin
          state_d = ST_SKIP;
        end
        default: begin
          state_d = ST_B0;
        end
      endcase

      if (fail_now) begin
        drop_d = 1'b1;
      end

      // tlast closes the frame from any state, after the beat's own processing.
      if (s_axis_tlast) begin
        state_d = ST_B0;
        drop_d  = 1'b0;
      end
    end

    if (emit) begin
      out_key_d   = KEY_SIZE'({src_ip_q, dst_hi_q, dst_lo, dport, 16'h0000});
      out_flag_d  = (sport == WATCH_PORT) ? FLAG_INSERT : FLAG_LOOKUP;
      out_valid_d = 1'b1;
    end
  end

  // State, capture and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_B0;
      src_ip_q    <= '0;
      dst_hi_q    <= '0;
      drop_q      <= 1'b0;
      out_key_q   <= '0;
      out_flag_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_ip_q    <= src_ip_d;
      dst_hi_q    <= dst_hi_d;
      drop_q      <= drop_d;
      out_key_q   <= out_key_d;
      out_flag_q  <= out_flag_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_key   = out_key_q;
  assign out_flag  = out_flag_q;
  assign out_valid = out_valid_q;
  assign dbg_state = state_q;

`ifdef PARSER_STATS_EN
  logic [CNT_WIDTH-1:0] frames_q, frames_d;
  logic [CNT_WIDTH-1:0] keys_q, keys_d;
  logic [CNT_WIDTH-1:0] drops_q, drops_d;
  logic                 rejected;

  // Count frame ends, emitted keys and rejected frames; counters wrap naturally.
  always_comb begin
    frames_d = frames_q;
    keys_d   = keys_q;
    drops_d  = drops_q;
    // A frame ending before beat 4 was truncated; otherwise it is rejected only
    // if some check failed (now or earlier in the frame).
    rejected = drop_q || fail_now || ((state_q != ST_B4) && (state_q != ST_SKIP));
    if (beat && s_axis_tlast) begin
      frames_d = frames_q + CNT_WIDTH'(1);
      if (rejected) begin
        drops_d = drops_q + CNT_WIDTH'(1);
      end
    end
    if (emit) begin
      keys_d = keys_q + CNT_WIDTH'(1);
    end
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      frames_q <= '0;
      keys_q   <= '0;
      drops_q  <= '0;
    end else begin
      frames_q <= frames_d;
      keys_q   <= keys_d;
      drops_q  <= drops_d;
    end
  end

  assign stat_frames = frames_q;
  assign stat_keys   = keys_q;
  assign stat_drops  = drops_q;
`else
  assign stat_frames = '0;
  assign stat_keys   = '0;
  assign stat_drops  = '0;
`endif

endmodule
